// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift unit: FSM state encoding and
// shift-direction constants used by iter_shifter and shift_step.
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves i_data by STEP bit positions in
// the requested direction, with zero or sign fill on right shifts.
module shift_step
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 1
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_dir,
    input  logic                  i_arith,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic signed [DATA_WIDTH-1:0] w_sdata;

    assign w_sdata = i_data;

    // Select left, logical-right or arithmetic-right shift by STEP
    always_comb begin
        o_data = i_data;
        if (i_dir == DIR_LEFT) begin
            o_data = i_data << STEP;
        end else if (i_arith) begin
            o_data = w_sdata >>> STEP;
        end else begin
            o_data = i_data >> STEP;
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle iterative shifter with start/busy/done handshake.
// Shifts one bit per clock; defining ITER_SHIFTER_STEP4_EN adds a 4-bit step
// used while at least 4 positions remain.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   dir,
    input  logic                   arith,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  dout
);

    // Count is wide enough to hold DATA_WIDTH itself (clamped amounts on
    // non-power-of-2 widths) and the constant 4 used by the wide step.
    localparam int CW_RAW = $clog2(DATA_WIDTH + 1);
    localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;
    localparam logic [CW-1:0] W_CNT = CW'(DATA_WIDTH);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [CW-1:0]         r_count;
    logic                  r_dir;
    logic                  r_arith;
    logic                  r_busy;
    logic                  r_done;

    logic [CW-1:0]         w_shamt_ext;
    logic [CW-1:0]         w_start_cnt;
    logic [DATA_WIDTH-1:0] w_step1;
    logic [DATA_WIDTH-1:0] w_next_data;
    logic [CW-1:0]         w_next_count;

    assign w_shamt_ext = CW'(shamt);
    assign w_start_cnt = (w_shamt_ext >= W_CNT) ? W_CNT : w_shamt_ext;

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (1)
    ) u_step1 (
        .i_data  (r_dout),
        .i_dir   (r_dir),
        .i_arith (r_arith),
        .o_data  (w_step1)
    );

`ifdef ITER_SHIFTER_STEP4_EN
    logic [DATA_WIDTH-1:0] w_step4;
    logic                  w_use4;

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (4)
    ) u_step4 (
        .i_data  (r_dout),
        .i_dir   (r_dir),
        .i_arith (r_arith),
        .o_data  (w_step4)
    );

    assign w_use4       = (r_count >= CW'(4));
    assign w_next_data  = w_use4 ? w_step4 : w_step1;
    assign w_next_count = r_count - (w_use4 ? CW'(4) : CW'(1));
`else
    assign w_next_data  = w_step1;
    assign w_next_count = r_count - CW'(1);
`endif

    // Control FSM with registered busy/done and the result/operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dout  <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dout  <= din;
                        r_dir   <= dir;
                        r_arith <= arith;
                        r_count <= w_start_cnt;
                        if (w_start_cnt == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_dout  <= w_next_data;
                    r_count <= w_next_count;
                    if (w_next_count == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule
